nn_argmax_out: RTL and testbench
================================

# nn_argmax_out

Output stage of the generated inference pipeline. It sits directly downstream of the last linear layer and consumes that layer's signed MAC results once the layer signals done. It snapshots the result vector and scans it sequentially, one element per cycle. It presents the winning class index and its value to the host over a valid/ready handshake.

## Interface
- `N_IN`, default 4: number of input elements (final-layer outputs); must be ≥ 1.
- `DW`, default 10: element width (signed two's complement; matches final-layer MAC width).
- `IDXW`, default `$clog2(N_IN)` (min 1): width of the class index.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `start`  in  1  single-cycle pulse; driven by the upstream layer's done.
- `in_vec`  in  N_IN*DW  packed elements; element k occupies bits [k*DW +: DW].
- `busy`  out  1  high in SCAN and HOLD.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  host accepts result.
- `out_idx`  out  IDXW  index of the maximum element.
- `out_max`  out  DW  value of the maximum element, signed.
- `overrun`  out  1  sticky flag: a start was dropped.

## Operation
- States: IDLE, SCAN, HOLD.
- IDLE + start:
  - copy all of `in_vec` into an internal snapshot register bank.
  - load best_val = element 0 and best_idx = 0.
  - load scan counter = 1.
  - go to SCAN, or straight to HOLD if N_IN = 1.
- SCAN, each cycle:
  - compare snapshot[cnt] with best_val using a signed comparison.
  - replace best_val and best_idx only if strictly greater, so ties keep the lowest index.
  - when cnt = N_IN-1, go to HOLD after this update; otherwise increment cnt.
- HOLD:
  - `out_valid` = 1; `out_idx`/`out_max` driven from the best registers and stable.
  - `out_valid & out_ready` at a clock edge: transfer occurs; go to IDLE.
  - If `start` is also high in that cycle, perform the IDLE+start capture in the same edge and go to SCAN. Back-to-back operation, no overrun.
- `start` in SCAN, or in HOLD without `out_ready`: ignored, `overrun` ← 1. The snapshot is unaffected.
- `overrun` clears only on reset or on the next accepted start.
- `in_vec` is sampled only at the accepted-start edge. Later changes have no effect on the current result.
- Width rules:
  - All comparisons are signed, DW bits. No arithmetic beyond the compare.
  - Counter width is IDXW; the counter never exceeds N_IN-1.
- Reset (any time, including mid-SCAN or in HOLD):
  - state → IDLE; `out_valid`, `busy`, `overrun` → 0; `out_idx`, `out_max` → 0; snapshot and counter → 0.
  - An aborted scan never produces `out_valid`.

## Timing
- Start sampled high at the edge ending cycle 0.
- Cycles 1..N_IN-1 are SCAN; `out_valid` first high in cycle N_IN (cycle 4 for N_IN = 4; cycle 1 for N_IN = 1).
- `busy` is high from cycle 1 through the last HOLD cycle.
- After the transfer edge, `out_valid` is low in the following cycle, unless a back-to-back start was taken. In that case `out_valid` is low for the N_IN-1 cycles of SCAN.
- `out_valid` does not depend combinationally on `out_ready`. All outputs are registered or decoded from registered state.
- Throughput: one result per N_IN cycles with `out_ready` held high and `start` arriving in each HOLD cycle.

## Structure
- Shared package `nn_pkg`:
  - state typedef `nn_seq_state_t` {IDLE, SCAN, HOLD}, reusable by the layer control units.
  - default data width constant `NN_ACC_W` = 10.
- Single module, no sub-module.
  - The comparator and element mux are inline.
  - The snapshot bank is a `DW`-wide register array indexed by the counter.

## Test plan
- N_IN=4, DW=10, in_vec={e0=5,e1=-3,e2=100,e3=7}, start pulse, out_ready=1 → out_valid in cycle 4 for one cycle, out_idx=2, out_max=100, overrun=0.
- Ties, {42,42,-1,42} → out_idx=0, out_max=42.
- Signed check, {3,-1,-512,2} → out_idx=0, out_max=3 (an unsigned compare would wrongly give idx 1).
- Backpressure:
  - out_ready=0 for 10 cycles after valid; change in_vec and pulse start during HOLD.
  - → outputs stay {idx,max} unchanged, overrun=1.
  - Raise out_ready → single transfer, out_valid low next cycle, overrun still 1 until the next accepted start.
- Back-to-back:
  - In HOLD, drive out_ready=1 and start=1 with new in_vec {0,0,0,9} in the same cycle.
  - → transfer of the old result, overrun=0, out_valid low for 3 cycles, then out_idx=3, out_max=9.
- Reset mid-SCAN:
  - Assert rst in cycle 2 after start → all outputs 0 immediately (asynchronous); out_valid never rises.
  - After deassertion, a new start with {1,2,3,4} → out_idx=3 in cycle 4.

Source files
------------

// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the generated inference pipeline.
//   nn_seq_state_t : IDLE / SCAN / HOLD sequencing state, shared by the layer
//                    control units and the argmax output stage.
//   NN_ACC_W       : default MAC / activation data width.
//   nn_idx_w       : index width for an N-element vector (never below 1).
// -----------------------------------------------------------------------------
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } nn_seq_state_t;

  localparam int NN_ACC_W = 10;

  // A one-element vector still needs a 1-bit index port.
  function automatic int nn_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : nn_pkg

// File: rtl/nn_argmax_out.sv
// -----------------------------------------------------------------------------
// nn_argmax_out
// Output stage of the inference pipeline. On an accepted start it snapshots the
// final layer's signed results, scans them one element per cycle and offers the
// index and value of the largest element to the host over valid/ready.
//
// Parameters
//   N_IN  number of elements (>= 1)
//   DW    element width, signed two's complement
//   IDXW  class-index width
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   single-cycle pulse from the upstream layer's done
//   in_vec     in   packed elements, element k at [k*DW +: DW]
//   busy       out  high while scanning or holding a result
//   out_valid  out  result available
//   out_ready  in   host accepts the result
//   out_idx    out  index of the maximum element (lowest index on ties)
//   out_max    out  value of the maximum element, signed
//   overrun    out  sticky: a start arrived while it could not be taken
// -----------------------------------------------------------------------------
module nn_argmax_out
  import nn_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int DW   = NN_ACC_W,
  parameter int IDXW = nn_idx_w(N_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_IN*DW-1:0]   in_vec,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDXW-1:0]      out_idx,
  output logic [DW-1:0]        out_max,
  output logic                 overrun
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_SCAN = 2'(SCAN);
  localparam logic [1:0] S_HOLD = 2'(HOLD);

  // A single element is already the maximum, so the scan is skipped.
  localparam logic [1:0]      S_AFTER_START = (N_IN > 1) ? S_SCAN : S_HOLD;
  localparam logic [IDXW-1:0] LAST_IDX      = IDXW'(N_IN - 1);
  localparam logic [IDXW-1:0] FIRST_CNT     = (N_IN > 1) ? IDXW'(1) : '0;

  logic [1:0]             r_state;
  logic signed [DW-1:0]   r_snap [N_IN];
  logic [IDXW-1:0]        r_cnt;
  logic signed [DW-1:0]   r_best_val;
  logic [IDXW-1:0]        r_best_idx;
  logic                   r_overrun;

  logic                   w_in_idle;
  logic                   w_in_hold;
  logic                   w_start_ok;
  logic                   w_start_drop;
  logic signed [DW-1:0]   w_elem;
  logic                   w_gt;
  logic                   w_last;

  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_hold = (r_state == S_HOLD);

  // A start is taken in IDLE, or in HOLD on the very edge the current result
  // is handed over; anywhere else it is dropped and flagged.
  assign w_start_ok   = start & (w_in_idle | (w_in_hold & out_ready));
  assign w_start_drop = start & ~w_start_ok;

  // Element mux and signed strict compare: ties keep the earlier index.
  assign w_elem = r_snap[r_cnt];
  assign w_gt   = (w_elem > r_best_val);
  assign w_last = (r_cnt == LAST_IDX);

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      // NOTE: the snapshot bank is cleared on reset on purpose so that no
      // stale data from an aborted scan survives; it is small enough that a
      // resettable register bank costs nothing worth avoiding.
      r_snap     <= '{default: '0};
      r_cnt      <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        for (int k = 0; k < N_IN; k++) begin
          r_snap[k] <= in_vec[k*DW +: DW];
        end
        r_best_val <= in_vec[DW-1:0];
        r_best_idx <= '0;
        r_cnt      <= FIRST_CNT;
        r_state    <= S_AFTER_START;
        r_overrun  <= 1'b0;
      end else begin
        if (w_start_drop) begin
          r_overrun <= 1'b1;
        end

        case (r_state)
          S_SCAN: begin
            if (w_gt) begin
              r_best_val <= w_elem;
              r_best_idx <= r_cnt;
            end
            if (w_last) begin
              r_state <= S_HOLD;
            end else begin
              r_cnt <= r_cnt + IDXW'(1);
            end
          end
          S_HOLD: begin
            if (out_ready) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Every output is decoded from registered state, so out_valid has no
  // combinational path from out_ready.
  assign busy      = ~w_in_idle;
  assign out_valid = w_in_hold;
  assign out_idx   = r_best_idx;
  assign out_max   = r_best_val;
  assign overrun   = r_overrun;

endmodule : nn_argmax_out

// File: tb/tb_nn_argmax_out.sv
// -----------------------------------------------------------------------------
// tb_nn_argmax_out
// Scoreboarded bench for nn_argmax_out (N_IN = 4, DW = 10). Each accepted start
// pushes the reference argmax of its vector; a monitor pops and compares on
// every valid&ready handshake. Directed checks cover reset, timing,
// backpressure, back-to-back and asynchronous reset; a random phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nn_argmax_out;

  localparam int N_IN = 4;
  localparam int DW   = 10;
  localparam int IDXW = 2;

  typedef struct {
    int idx;
    int mx;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [N_IN*DW-1:0]  in_vec;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic [IDXW-1:0]     out_idx;
  logic [DW-1:0]       out_max;
  logic                overrun;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  nn_argmax_out #(.N_IN(N_IN), .DW(DW), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_vec    (in_vec),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_max   (out_max),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_IN*DW-1:0] pack4(input int e0, input int e1,
                                               input int e2, input int e3);
    logic [N_IN*DW-1:0] v;
    v = '0;
    v[0*DW +: DW] = DW'(e0);
    v[1*DW +: DW] = DW'(e1);
    v[2*DW +: DW] = DW'(e2);
    v[3*DW +: DW] = DW'(e3);
    return v;
  endfunction

  // Reference: find the maximum value, then the first position holding it.
  function automatic exp_t ref_model(input logic [N_IN*DW-1:0] v);
    int   vals[N_IN];
    int   mx;
    exp_t r;
    for (int k = 0; k < N_IN; k++) vals[k] = int'($signed(v[k*DW +: DW]));
    mx = vals[0];
    foreach (vals[k]) if (vals[k] > mx) mx = vals[k];
    r.mx  = mx;
    r.idx = -1;
    for (int k = N_IN - 1; k >= 0; k--) if (vals[k] == mx) r.idx = k;
    return r;
  endfunction

  function automatic logic [N_IN*DW-1:0] rand_vec();
    logic [N_IN*DW-1:0] v;
    for (int k = 0; k < N_IN; k++) begin
      case ($urandom_range(0, 5))
        0:       v[k*DW +: DW] = DW'(-512);
        1:       v[k*DW +: DW] = DW'(511);
        2:       v[k*DW +: DW] = DW'($urandom_range(0, 3));
        default: v[k*DW +: DW] = DW'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an accepted start for this cycle and record its expected result.
  task automatic drive_start(input logic [N_IN*DW-1:0] v);
    in_vec = v;
    start  = 1'b1;
    sb_q.push_back(ref_model(v));
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 4 * N_IN && !out_valid; i++) tick();
    check(name, int'(out_valid), 1);
  endtask

  // One complete transaction with out_ready held high.
  task automatic run_one(input logic [N_IN*DW-1:0] v);
    out_ready = 1'b1;
    drive_start(v);
    tick();
    start = 1'b0;
    wait_valid("run_one_valid");
    tick();
    check("run_one_valid_drop", int'(out_valid), 0);
  endtask

  // Monitor: compare on every handshake, flag any result nobody expected.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_idx", int'(out_idx), e.idx);
        check("sb_max", int'($signed(out_max)), e.mx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit inflight;
    bit b2b;

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    in_vec    = '0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_idx", int'(out_idx), 0);
    check("rst_max", int'(out_max), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic timing: valid exactly in cycle 4, for one cycle.
    out_ready = 1'b1;
    drive_start(pack4(5, -3, 100, 7));
    tick();
    start = 1'b0;
    check("t1_busy_c1", int'(busy), 1);
    check("t1_valid_c1", int'(out_valid), 0);
    tick();
    tick();
    check("t1_valid_c3", int'(out_valid), 0);
    tick();
    check("t1_valid_c4", int'(out_valid), 1);
    check("t1_idx", int'(out_idx), 2);
    check("t1_max", int'($signed(out_max)), 100);
    check("t1_overrun", int'(overrun), 0);
    tick();
    check("t1_valid_c5", int'(out_valid), 0);
    check("t1_busy_c5", int'(busy), 0);

    // Ties keep the lowest index; signed compare.
    run_one(pack4(42, 42, -1, 42));
    run_one(pack4(3, -1, -512, 2));

    // Backpressure with a dropped start during HOLD.
    out_ready = 1'b0;
    drive_start(pack4(10, 20, 30, -40));
    tick();
    start = 1'b0;
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_vec = pack4(500, 0, 0, 0);
        start  = 1'b1;
      end
      tick();
      start = 1'b0;
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_idx", int'(out_idx), 2);
      check("bp_hold_max", int'($signed(out_max)), 30);
    end
    check("bp_overrun_set", int'(overrun), 1);
    out_ready = 1'b1;
    tick();
    check("bp_valid_after", int'(out_valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);

    // Back-to-back: start in the transfer cycle clears overrun.
    out_ready = 1'b0;
    drive_start(pack4(1, -2, 3, -4));
    tick();
    start = 1'b0;
    check("b2b_overrun_clr", int'(overrun), 0);
    wait_valid("b2b_first_valid");
    tick();
    out_ready = 1'b1;
    drive_start(pack4(0, 0, 0, 9));
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    check("b2b_overrun", int'(overrun), 0);
    for (int i = 0; i < N_IN - 1; i++) begin
      check("b2b_scan_valid", int'(out_valid), 0);
      check("b2b_scan_busy", int'(busy), 1);
      tick();
    end
    check("b2b_valid", int'(out_valid), 1);
    check("b2b_idx", int'(out_idx), 3);
    check("b2b_max", int'($signed(out_max)), 9);
    out_ready = 1'b1;
    tick();
    check("b2b_done", int'(out_valid), 0);

    // Asynchronous reset in cycle 2 of a scan.
    out_ready = 1'b1;
    drive_start(pack4(7, 8, 9, 10));
    tick();
    start = 1'b0;
    tick();
    #1;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(out_valid), 0);
    check("arst_idx", int'(out_idx), 0);
    check("arst_max", int'(out_max), 0);
    check("arst_overrun", int'(overrun), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2 * N_IN; i++) begin
      tick();
      check("arst_no_valid", int'(out_valid), 0);
    end
    drive_start(pack4(1, 2, 3, 4));
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("arst_new_valid_c4", int'(out_valid), 1);
    check("arst_new_idx", int'(out_idx), 3);
    tick();

    // Random phase: random vectors, backpressure, dropped and back-to-back starts.
    out_ready = 1'b0;
    inflight  = 1'b0;
    for (int it = 0; it < 60; it++) begin
      if (!inflight) begin
        drive_start(rand_vec());
        tick();
        start = 1'b0;
      end
      wait_valid("rnd_valid");
      for (int d = $urandom_range(0, 3); d > 0; d--) begin
        if ($urandom_range(0, 3) == 0) begin
          in_vec = rand_vec();
          start  = 1'b1;
          tick();
          start = 1'b0;
          check("rnd_overrun", int'(overrun), 1);
        end else begin
          tick();
        end
      end
      out_ready = 1'b1;
      b2b       = 1'($urandom_range(0, 1));
      if (b2b) drive_start(rand_vec());
      tick();
      start     = 1'b0;
      out_ready = 1'b0;
      check("rnd_valid_drop", int'(out_valid), 0);
      if (b2b) check("rnd_b2b_overrun", int'(overrun), 0);
      inflight = b2b;
    end
    if (inflight) begin
      wait_valid("rnd_last_valid");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    tick();

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_nn_argmax_out
